// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bundle between the two writeback sources, decode scoreboard
// updates and the regfile write port.
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   localparam int NREG = 2**ADDR_W;

   logic              src0_valid;
   logic              src0_ready;
   logic [ADDR_W-1:0] src0_waddr;
   logic [DATA_W-1:0] src0_wdata;
   logic              src1_valid;
   logic              src1_ready;
   logic [ADDR_W-1:0] src1_waddr;
   logic [DATA_W-1:0] src1_wdata;
   logic              sb_set;
   logic [ADDR_W-1:0] sb_addr;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [NREG-1:0]   busy;

   modport master (
      output src0_valid, src0_waddr, src0_wdata,
      output src1_valid, src1_waddr, src1_wdata,
      output sb_set, sb_addr,
      input  src0_ready, src1_ready,
      input  rf_we, rf_waddr, rf_wdata, busy
   );

   modport slave (
      input  src0_valid, src0_waddr, src0_wdata,
      input  src1_valid, src1_waddr, src1_wdata,
      input  sb_set, sb_addr,
      output src0_ready, src1_ready,
      output rf_we, rf_waddr, rf_wdata, busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter onto the single regfile write port, with a RAW busy scoreboard.
// WB_ARB_STARVE_EN enables the src1 starvation override; otherwise src0 has strict priority.

// One scoreboard bit: set (from decode) beats clear (from a src1 writeback).
module regfile_wb_sb_bit (
   input  logic clk,
   input  logic resetn,
   input  logic set,
   input  logic clr,
   output logic busy
);
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)  busy <= 1'b0;
      else if (set) busy <= 1'b1;
      else if (clr) busy <= 1'b0;
   end
endmodule

module regfile_wb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int NREG = 2**ADDR_W;

   typedef struct packed {
      logic              we;
      logic              src1;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
   } wr_t;

   if (STARVE_MAX < 1) begin : g_bad_param
      $error("STARVE_MAX must be at least 1");
   end

   logic starve;
   logic g0, g1;
   wr_t  wr_q;

`ifdef WB_ARB_STARVE_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0] starve_cnt;

   assign starve = (starve_cnt == CNT_W'(STARVE_MAX));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         starve_cnt <= '0;
      else if (g1)
         starve_cnt <= '0;
      else if (bus.src1_valid && !bus.src1_ready && !starve)
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   assign starve = 1'b0;
`endif

   // Readies are held low during reset so nothing can be accepted while the port is cleared.
   assign bus.src1_ready = resetn && bus.src1_valid && (!bus.src0_valid || starve);
   assign bus.src0_ready = resetn && !(bus.src1_valid && starve);

   assign g0 = bus.src0_valid && bus.src0_ready;
   assign g1 = bus.src1_valid && bus.src1_ready;

   // r0 writes are accepted but never enable the regfile write.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_q <= '0;
      end else begin
         wr_q.we <= (g0 && (bus.src0_waddr != '0)) || (g1 && (bus.src1_waddr != '0));
         if (g1) begin
            wr_q.src1  <= 1'b1;
            wr_q.waddr <= bus.src1_waddr;
            wr_q.wdata <= bus.src1_wdata;
         end else if (g0) begin
            wr_q.src1  <= 1'b0;
            wr_q.waddr <= bus.src0_waddr;
            wr_q.wdata <= bus.src0_wdata;
         end
      end
   end

   assign bus.rf_we    = wr_q.we;
   assign bus.rf_waddr = wr_q.waddr;
   assign bus.rf_wdata = wr_q.wdata;

   assign bus.busy[0] = 1'b0;

   for (genvar i = 1; i < NREG; i++) begin : g_sb
      logic set_i, clr_i;
      assign set_i = bus.sb_set && (bus.sb_addr == ADDR_W'(i));
      assign clr_i = wr_q.we && wr_q.src1 && (wr_q.waddr == ADDR_W'(i));

      regfile_wb_sb_bit u_sb (
         .clk    (clk),
         .resetn (resetn),
         .set    (set_i),
         .clr    (clr_i),
         .busy   (bus.busy[i])
      );
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow WB_ARB_STARVE_EN.
module tb_regfile_wb_arbiter;
   logic clk;
   logic resetn;
   int   n_chk;
   int   n_err;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.src0_valid = 1'b0;
      bus.src1_valid = 1'b0;
      bus.sb_set     = 1'b0;
   endtask

   initial begin
      logic exp1;
      logic starve_en;
`ifdef WB_ARB_STARVE_EN
      starve_en = 1'b1;
`else
      starve_en = 1'b0;
`endif
      n_chk = 0;
      n_err = 0;
      resetn = 1'b0;
      idle();
      bus.src0_waddr = '0; bus.src0_wdata = '0;
      bus.src1_waddr = '0; bus.src1_wdata = '0;
      bus.sb_addr    = '0;
      bus.src1_valid = 1'b1;
      #3;
      check("rst_we",    bus.rf_we,      0);
      check("rst_waddr", bus.rf_waddr,   0);
      check("rst_wdata", bus.rf_wdata,   0);
      check("rst_busy",  bus.busy,       0);
      check("rst_s0r",   bus.src0_ready, 0);
      check("rst_s1r",   bus.src1_ready, 0);
      tick();
      resetn = 1'b1;
      idle();
      tick();

      // single src0 write
      bus.src0_valid = 1'b1; bus.src0_waddr = 5; bus.src0_wdata = 32'h11;
      #1;
      check("t1_s0r", bus.src0_ready, 1);
      check("t1_s1r", bus.src1_ready, 0);
      tick();
      idle();
      check("t1_we",    bus.rf_we,    1);
      check("t1_waddr", bus.rf_waddr, 5);
      check("t1_wdata", bus.rf_wdata, 32'h11);
      tick();
      check("t1_we_off",    bus.rf_we,    0);
      check("t1_waddr_hold", bus.rf_waddr, 5);
      check("t1_wdata_hold", bus.rf_wdata, 32'h11);

      // contention for 8 cycles
      for (int c = 0; c < 8; c++) begin
         bus.src0_valid = 1'b1; bus.src0_waddr = 1; bus.src0_wdata = 32'(c);
         bus.src1_valid = 1'b1; bus.src1_waddr = 2; bus.src1_wdata = 32'hBEEF;
         #1;
         exp1 = starve_en && (c == 4);
         check($sformatf("t2_s1r_c%0d", c), bus.src1_ready, exp1);
         check($sformatf("t2_s0r_c%0d", c), bus.src0_ready, !exp1);
         tick();
         check($sformatf("t2_waddr_c%0d", c), bus.rf_waddr, exp1 ? 2 : 1);
      end
      bus.src0_valid = 1'b0;
      #1;
      check("t2_s1r_free", bus.src1_ready, 1);
      tick();
      idle();
      check("t2_s1_waddr", bus.rf_waddr, 2);
      check("t2_s1_wdata", bus.rf_wdata, 32'hBEEF);
      tick();

      // scoreboard set then cleared by src1 writeback
      bus.sb_set = 1'b1; bus.sb_addr = 7;
      tick();
      bus.sb_set = 1'b0;
      check("t3_busy_set", bus.busy[7], 1);
      bus.src1_valid = 1'b1; bus.src1_waddr = 7; bus.src1_wdata = 32'hDEAD;
      #1;
      check("t3_s1r", bus.src1_ready, 1);
      tick();
      idle();
      check("t3_we",        bus.rf_we,    1);
      check("t3_waddr",     bus.rf_waddr, 7);
      check("t3_wdata",     bus.rf_wdata, 32'hDEAD);
      check("t3_busy_wecy", bus.busy[7],  1);
      tick();
      check("t3_busy_clr", bus.busy[7], 0);

      // set and clear collide: set wins
      bus.sb_set = 1'b1; bus.sb_addr = 7;
      tick();
      bus.sb_set = 1'b0;
      bus.src1_valid = 1'b1; bus.src1_waddr = 7; bus.src1_wdata = 32'hBEEF;
      tick();
      bus.src1_valid = 1'b0;
      check("t3b_we", bus.rf_we, 1);
      bus.sb_set = 1'b1; bus.sb_addr = 7;
      tick();
      bus.sb_set = 1'b0;
      check("t3b_set_wins", bus.busy[7], 1);
      bus.src1_valid = 1'b1; bus.src1_waddr = 7; bus.src1_wdata = 32'h1;
      tick();
      bus.src1_valid = 1'b0;
      tick();
      check("t3b_busy_clr", bus.busy[7], 0);

      // src0 writes leave busy alone
      bus.sb_set = 1'b1; bus.sb_addr = 9;
      tick();
      bus.sb_set = 1'b0;
      bus.src0_valid = 1'b1; bus.src0_waddr = 9; bus.src0_wdata = 32'h99;
      tick();
      bus.src0_valid = 1'b0;
      check("t3c_we", bus.rf_we, 1);
      tick();
      check("t3c_busy_kept", bus.busy[9], 1);

      // r0 write and r0 scoreboard set
      bus.src1_valid = 1'b1; bus.src1_waddr = 0; bus.src1_wdata = 32'h5A;
      bus.sb_set = 1'b1; bus.sb_addr = 0;
      #1;
      check("t4_s1r", bus.src1_ready, 1);
      tick();
      idle();
      check("t4_we",    bus.rf_we,   0);
      check("t4_busy0", bus.busy[0], 0);
      check("t4_busy",  bus.busy,    64'h200);

      // async reset with a write registered and r3 busy
      bus.sb_set = 1'b1; bus.sb_addr = 3;
      tick();
      bus.sb_set = 1'b0;
      bus.src0_valid = 1'b1; bus.src0_waddr = 4; bus.src0_wdata = 32'h44;
      tick();
      bus.src1_valid = 1'b1; bus.src1_waddr = 6; bus.src1_wdata = 32'h66;
      check("t5_we_pre",   bus.rf_we,   1);
      check("t5_busy_pre", bus.busy[3], 1);
      #2;
      resetn = 1'b0;
      #1;
      check("t5_we",    bus.rf_we,      0);
      check("t5_busy",  bus.busy,       0);
      check("t5_s0r",   bus.src0_ready, 0);
      check("t5_s1r",   bus.src1_ready, 0);
      check("t5_waddr", bus.rf_waddr,   0);
      idle();
      #2;
      resetn = 1'b1;
      tick();
      check("t5_post_we0", bus.rf_we, 0);
      tick();
      check("t5_post_we1", bus.rf_we, 0);
      check("t5_post_busy", bus.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
